// File: rtl/gauss_pkg.sv
// Shared types and defaults for the Gaussian stream filter.
// Mode and FSM state enums are used by the top and the bench alike.
package gauss_pkg;

    typedef enum logic [1:0] {
        MODO_GAUSS  = 2'b00,
        MODO_BYPASS = 2'b01,
        MODO_CROSS  = 2'b10,
        MODO_RSVD   = 2'b11
    } modo_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;

endpackage

// File: rtl/gaussian_stream_filter_line_buffer.sv
// Fixed-length delay line: on each enable it accepts one word and presents the word
// written DEPTH enables earlier. Circular RAM with a registered, look-ahead read.
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_next;
    logic [WIDTH-1:0] r_rd;

    always_comb begin
        w_ptr_next = r_ptr;
        if (rst) begin
            w_ptr_next = '0;
        end else if (i_en) begin
            w_ptr_next = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    // Read address runs one slot ahead of the write, so r_rd always mirrors r_mem[r_ptr]
    // and never collides with the word being written this cycle.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
        r_rd <= r_mem[w_ptr_next];
    end

    assign o_dout = r_rd;

endmodule

// File: rtl/gaussian_stream_filter.sv
// Streaming 3x3 filter (Gaussian / cross / bypass) over a raster-order image.
// Two line buffers plus a 3x3 register window; one output per interior centre.
module gaussian_stream_filter
    import gauss_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [1:0]       modo,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int ACC_W = PIX_W + 4;

    state_t           r_state;
    state_t           w_state_next;
    modo_t            r_modo;
    modo_t            r_win_modo;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_out_valid;
    logic             r_frame_done;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_last_pix;
    logic             w_interior;
    logic [PIX_W-1:0] w_lb0;
    logic [PIX_W-1:0] w_lb1;
    logic [PIX_W-1:0] w_col_new [3];
    logic [PIX_W-1:0] w_win [3][3];
    logic [ACC_W-1:0] w_gauss_sum;
    logic [ACC_W-1:0] w_cross_sum;
    logic [PIX_W-1:0] w_result;

    // A start pulse always takes priority over any input offered in the same cycle.
    assign w_accept   = in_valid && w_in_ready && !inicio;
    assign w_last_col = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
    assign w_last_pix = w_last_col && w_last_row;
    assign w_interior = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (inicio) w_state_next = ST_RUN;
            ST_RUN: begin
                if (inicio) begin
                    w_state_next = ST_RUN;
                end else if (w_accept && w_last_pix) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        if (r_state == ST_RUN) begin
            w_in_ready = !r_out_valid || out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_modo <= MODO_GAUSS;
        end else if (inicio) begin
            r_col  <= '0;
            r_row  <= '0;
            r_modo <= modo_t'(modo);
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_modo   <= MODO_GAUSS;
        end else begin
            r_frame_done <= w_accept && w_last_pix;
            if (w_accept) begin
                r_win_modo <= r_modo;
            end
            if (inicio && (r_state == ST_RUN)) begin
                r_out_valid <= 1'b0;
            end else if (w_accept && w_interior) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb0 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_accept),
        .i_din  (in_pixel),
        .o_dout (w_lb0)
    );

    line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_accept),
        .i_din  (w_lb0),
        .o_dout (w_lb1)
    );

    // Window row 0 is image row r-2, row 2 is the incoming row r.
    assign w_col_new[0] = w_lb1;
    assign w_col_new[1] = w_lb0;
    assign w_col_new[2] = in_pixel;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            logic [PIX_W-1:0] r_tap [3];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tap[0] <= '0;
                    r_tap[1] <= '0;
                    r_tap[2] <= '0;
                end else if (w_accept) begin
                    r_tap[0] <= r_tap[1];
                    r_tap[1] <= r_tap[2];
                    r_tap[2] <= w_col_new[gi];
                end
            end

            assign w_win[gi][0] = r_tap[0];
            assign w_win[gi][1] = r_tap[1];
            assign w_win[gi][2] = r_tap[2];
        end
    endgenerate

    // The window and its mode change only on input transfers, which are blocked while an
    // output is stalled, so the combinational result stays stable for the whole handshake.
    always_comb begin
        w_gauss_sum = ACC_W'(w_win[0][0]) + ACC_W'(w_win[0][2])
                    + ACC_W'(w_win[2][0]) + ACC_W'(w_win[2][2])
                    + ((ACC_W'(w_win[0][1]) + ACC_W'(w_win[1][0])
                      + ACC_W'(w_win[1][2]) + ACC_W'(w_win[2][1])) << 1)
                    + (ACC_W'(w_win[1][1]) << 2);
        w_cross_sum = (ACC_W'(w_win[1][1]) << 2)
                    + ACC_W'(w_win[0][1]) + ACC_W'(w_win[2][1])
                    + ACC_W'(w_win[1][0]) + ACC_W'(w_win[1][2]);
        case (r_win_modo)
            MODO_GAUSS: w_result = PIX_W'(w_gauss_sum >> 4);
            MODO_CROSS: w_result = PIX_W'(w_cross_sum >> 3);
            default:    w_result = w_win[1][1];
        endcase
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_pixel  = w_result;
    assign frame_done = r_frame_done;

endmodule

// File: doc/gaussian_stream_filter.md
GAUSSIAN_STREAM_FILTER -- requirements
Module: gaussian_stream_filter

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 64, image width in pixels, SHALL be >= 3.
REQ-003 Parameter IMG_H, default 64, image height in pixels, SHALL be >= 3.
REQ-004 One clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 inicio  input  1  frame-start pulse.
REQ-008 modo  input  2  filter mode, sampled when a frame starts.
REQ-009 in_pixel  input  PIX_W  raster-order input pixel.
REQ-010 in_valid / in_ready  input / output  1  input handshake.
REQ-011 out_pixel  output  PIX_W  filtered pixel.
REQ-012 out_valid / out_ready  output / input  1  output handshake.
REQ-013 frame_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-014 FSM SHALL have states IDLE and RUN. Transitions:
- IDLE -> RUN when inicio=1; clears row/col counters and latches modo.
- RUN -> IDLE on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-015 Transfer rules:
- An input transfer occurs when in_valid and in_ready are both 1.
- An output transfer occurs when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be 0 in IDLE; in RUN it SHALL be (!out_valid || out_ready).
REQ-017 Window buffering:
- Two line buffers of IMG_W entries and a 3x3 register window SHALL hold rows r-2..r and columns c-2..c.
- All of these SHALL update only on input transfers.
REQ-018 Output SHALL be produced only for interior centres, i.e. when an input is accepted at row >= 2 and col >= 2.
- Output count per frame SHALL be (IMG_H-2)*(IMG_W-2).
REQ-019 Latency: out_pixel/out_valid SHALL assert the cycle after the qualifying input transfer.
- out_valid SHALL hold with a stable out_pixel until an output transfer occurs.
REQ-020 modo=00, Gaussian: (corners + 2*edges + 4*centre) >> 4.
REQ-021 modo=01, bypass: out_pixel = centre pixel.
REQ-022 modo=10, cross smoothing: (4*centre + N + S + E + W) >> 3.
REQ-023 modo=11 SHALL behave as bypass.
REQ-024 Arithmetic:
- Accumulation SHALL use PIX_W+4 bits, with no overflow.
- The shift SHALL truncate (floor).
- The result SHALL always fit in PIX_W bits.
REQ-025 Counters: col SHALL wrap from IMG_W-1 to 0 and increment row; row IMG_H-1 at col wrap ends the frame.
REQ-026 frame_done SHALL pulse one cycle after the final input transfer, coincident with the last out_valid assertion.
REQ-027 inicio during RUN SHALL abort the frame:
- counters clear;
- modo is relatched;
- a pending out_valid is dropped;
- the same cycle's input transfer, if any, is not accepted.
REQ-028 inicio simultaneous with rst: rst SHALL win.
REQ-029 out_ready=0 SHALL stall input via in_ready; no pixel is ever lost or duplicated.

Reset
REQ-030 On rst, the block SHALL set:
- state IDLE;
- counters 0;
- latched modo 00;
- out_valid 0;
- out_pixel 0;
- frame_done 0;
- in_ready 0.
REQ-031 Line-buffer contents need not be reset; rows 0-1 of every frame overwrite them before use.
REQ-032 Reset mid-frame SHALL discard the frame entirely; the next frame requires inicio.

Structure
REQ-033 Shared package gauss_pkg SHALL hold:
- the modo enum (MODO_GAUSS, MODO_BYPASS, MODO_CROSS, MODO_RSVD);
- the FSM state enum;
- default parameter constants.
REQ-034 One sub-module, line_buffer, SHALL be used: parametrised width and depth, single write/read port, shift-on-enable.

Verification
REQ-035 Constant image: 5x5, all pixels 100, modo 00 -> nine outputs, all 100, then one frame_done pulse.
REQ-036 Impulse: 5x5 with 255 at (2,2), all else 0, modo 00 -> 3x3 output 15,31,15 / 31,63,31 / 15,31,15.
REQ-037 Modes: same impulse, modo 10 -> centre 127, N/S/E/W 31, corners 0; modo 01 -> centre 255, others 0.
REQ-038 Backpressure: random out_ready (50%) with a ramp image -> output sequence identical to the no-stall run, and in_ready never 1 while out_valid=1 and out_ready=0.
REQ-039 Abort: inicio at pixel (3,1) of a frame -> no stale outputs appear; the fresh frame yields exactly (IMG_H-2)*(IMG_W-2) correct outputs.
REQ-040 Reset mid-frame: rst at pixel (2,3) -> next cycle out_valid=0, in_ready=0, state IDLE; then inicio plus a full frame -> correct output.
